// File: rtl/gtxe2_chnl_rx_sync_ctrl.sv
// gtxe2_chnl_rx_sync_ctrl: RX link-sync controller sequencing the comma aligner and qualifying lock.
//   clk, rst_n                    RXUSRCLK and asynchronous active-low reset
//   enable, rxelecidle            controller enable and electrical idle; either forces IDLE
//   rxbyteisaligned, rxbyterealign,
//   rxcommadet                    aligner status
//   rxdisperr, rxnotintable       per-byte 8b10b decoder error flags
//   rxpcommaalignen,
//   rxmcommaalignen, rxcommadeten aligner controls
//   sync_ok, state, err_cnt       lock status, FSM state (0 IDLE 1 HUNT 2 ACQ 3 LOCKED), error credit
//   hunt_timeout, sync_loss_cnt   HUNT timeout pulse, saturating LOCKED->HUNT event count
module gtxe2_chnl_rx_sync_ctrl #(
    parameter int ISK_WIDTH    = 2,
    parameter int LOCK_COMMAS  = 3,
    parameter int ERR_LIMIT    = 4,
    parameter int GOOD_RUN     = 16,
    parameter int HUNT_TIMEOUT = 1023,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rxelecidle,
    input  logic                 rxbyteisaligned,
    input  logic                 rxbyterealign,
    input  logic                 rxcommadet,
    input  logic [ISK_WIDTH-1:0] rxdisperr,
    input  logic [ISK_WIDTH-1:0] rxnotintable,
    output logic                 rxpcommaalignen,
    output logic                 rxmcommaalignen,
    output logic                 rxcommadeten,
    output logic                 sync_ok,
    output logic [1:0]           state,
    output logic [2:0]           err_cnt,
    output logic                 hunt_timeout,
    output logic [CNT_WIDTH-1:0] sync_loss_cnt
);
    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam int TW = $clog2(HUNT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HUNT, ACQ, LOCKED} state_t;

    state_t               st;
    logic [CW-1:0]        comma_cnt;
    logic [GW-1:0]        good_cnt;
    logic [TW-1:0]        timer;
    logic                 en, idle, realign, werr, ccw;
    logic [ISK_WIDTH-1:0] derr, nit;

    // Unknown input bits count as 0 so an undriven lane can never fake a comma or an error.
    always_comb begin
        en      = (enable === 1'b1);
        idle    = (rxelecidle === 1'b1);
        realign = (rxbyterealign === 1'b1);
        derr    = '0;
        nit     = '0;
        for (int i = 0; i < ISK_WIDTH; i++) begin
            derr[i] = (rxdisperr[i] === 1'b1);
            nit[i]  = (rxnotintable[i] === 1'b1);
        end
        werr = |(derr | nit);
        ccw  = (rxcommadet === 1'b1) & (rxbyteisaligned === 1'b1) & ~werr;
    end

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= IDLE;
            comma_cnt       <= '0;
            good_cnt        <= '0;
            timer           <= '0;
            err_cnt         <= '0;
            sync_loss_cnt   <= '0;
            rxpcommaalignen <= 1'b0;
            rxmcommaalignen <= 1'b0;
            rxcommadeten    <= 1'b0;
            sync_ok         <= 1'b0;
            hunt_timeout    <= 1'b0;
        end else begin
            hunt_timeout <= 1'b0;
            if (idle | ~en) begin
                st              <= IDLE;
                comma_cnt       <= '0;
                good_cnt        <= '0;
                timer           <= '0;
                err_cnt         <= '0;
                rxpcommaalignen <= 1'b0;
                rxmcommaalignen <= 1'b0;
                rxcommadeten    <= 1'b0;
                sync_ok         <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        st              <= HUNT;
                        timer           <= '0;
                        rxpcommaalignen <= 1'b1;
                        rxmcommaalignen <= 1'b1;
                        rxcommadeten    <= 1'b1;
                    end
                    HUNT: begin
                        if (ccw) begin
                            st              <= ACQ;
                            comma_cnt       <= CW'(1);
                            timer           <= '0;
                            rxpcommaalignen <= 1'b0;
                            rxmcommaalignen <= 1'b0;
                        end else if (timer == TW'(HUNT_TIMEOUT - 1)) begin
                            // Dropping the enables for one cycle re-arms the aligner.
                            timer           <= '0;
                            hunt_timeout    <= 1'b1;
                            rxpcommaalignen <= 1'b0;
                            rxmcommaalignen <= 1'b0;
                        end else begin
                            timer           <= timer + 1'b1;
                            rxpcommaalignen <= 1'b1;
                            rxmcommaalignen <= 1'b1;
                        end
                    end
                    ACQ: begin
                        if (werr | realign) begin
                            st              <= HUNT;
                            comma_cnt       <= '0;
                            timer           <= '0;
                            rxpcommaalignen <= 1'b1;
                            rxmcommaalignen <= 1'b1;
                        end else if (ccw) begin
                            if (comma_cnt == CW'(LOCK_COMMAS - 1)) begin
                                st        <= LOCKED;
                                comma_cnt <= '0;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                                sync_ok   <= 1'b1;
                            end else begin
                                comma_cnt <= comma_cnt + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Credit exhaustion is acted on from the registered count, so a
                        // realign coinciding with an error still yields a single loss event.
                        if (realign | (err_cnt == 3'(ERR_LIMIT))) begin
                            st              <= HUNT;
                            err_cnt         <= '0;
                            good_cnt        <= '0;
                            timer           <= '0;
                            sync_ok         <= 1'b0;
                            rxpcommaalignen <= 1'b1;
                            rxmcommaalignen <= 1'b1;
                            if (~&sync_loss_cnt) sync_loss_cnt <= sync_loss_cnt + 1'b1;
                        end else if (werr) begin
                            err_cnt  <= err_cnt + 1'b1;
                            good_cnt <= '0;
                        end else if (good_cnt == GW'(GOOD_RUN - 1)) begin
                            good_cnt <= '0;
                            if (err_cnt != 3'd0) err_cnt <= err_cnt - 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gtxe2_chnl_rx_sync_ctrl.sv
// tb_gtxe2_chnl_rx_sync_ctrl: directed self-checking bench for the RX link-sync controller.
module tb_gtxe2_chnl_rx_sync_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, rxelecidle, rxbyteisaligned, rxbyterealign, rxcommadet;
    logic [1:0]  rxdisperr, rxnotintable;
    logic        rxpcommaalignen, rxmcommaalignen, rxcommadeten, sync_ok, hunt_timeout;
    logic [1:0]  state;
    logic [2:0]  err_cnt;
    logic [15:0] sync_loss_cnt;
    int          errors = 0;
    int          checks = 0;
    int          seen;

    gtxe2_chnl_rx_sync_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rxelecidle(rxelecidle),
        .rxbyteisaligned(rxbyteisaligned), .rxbyterealign(rxbyterealign),
        .rxcommadet(rxcommadet), .rxdisperr(rxdisperr), .rxnotintable(rxnotintable),
        .rxpcommaalignen(rxpcommaalignen), .rxmcommaalignen(rxmcommaalignen),
        .rxcommadeten(rxcommadeten), .sync_ok(sync_ok), .state(state),
        .err_cnt(err_cnt), .hunt_timeout(hunt_timeout), .sync_loss_cnt(sync_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic commas(input int n);
        rxcommadet = 1'b1;
        step(n);
        rxcommadet = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; rxelecidle = 1'b0; rxbyteisaligned = 1'b1;
        rxbyterealign = 1'b0; rxcommadet = 1'b0; rxdisperr = '0; rxnotintable = '0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_outs", {rxpcommaalignen, rxmcommaalignen, rxcommadeten, sync_ok, hunt_timeout}, 0);
        chk("rst_cnts", {err_cnt, sync_loss_cnt}, 0);

        rst_n = 1'b1; enable = 1'b1;
        step();
        chk("idle_to_hunt", state, 1);
        chk("hunt_outs", {rxpcommaalignen, rxmcommaalignen, rxcommadeten, sync_ok}, 4'b1110);

        rxcommadet = 1'bx;
        step();
        chk("x_comma_ignored", state, 1);
        rxcommadet = 1'b0;

        rxcommadet = 1'b1;
        step();
        chk("acq_after_1", state, 2);
        chk("acq_align_off", {rxpcommaalignen, rxmcommaalignen, rxcommadeten}, 3'b001);
        step();
        chk("acq_after_2", state, 2);
        step();
        chk("locked_after_3", {state, sync_ok}, 3'b111);
        chk("locked_outs", {rxpcommaalignen, rxmcommaalignen, rxcommadeten, err_cnt}, 6'b001000);
        rxcommadet = 1'b0;

        rxdisperr = 2'b01; step(); chk("err1", err_cnt, 1);
        rxdisperr = 2'b00; rxnotintable = 2'b10; step(); chk("err2", err_cnt, 2);
        step(); chk("err3", err_cnt, 3);
        step(); chk("err4", {state, err_cnt}, {2'd3, 3'd4});
        rxnotintable = 2'b00;
        step();
        chk("loss_to_hunt", {state, sync_ok, err_cnt}, {2'd1, 1'b0, 3'd0});
        chk("loss_cnt1", sync_loss_cnt, 1);
        chk("loss_align_on", {rxpcommaalignen, rxmcommaalignen}, 2'b11);

        commas(3);
        chk("relock", state, 3);
        rxdisperr = 2'b10; step(); rxdisperr = 2'b00;
        chk("credit_err1", err_cnt, 1);
        step(15);
        chk("credit_held", {state, err_cnt}, {2'd3, 3'd1});
        step();
        chk("credit_retired", {state, err_cnt}, {2'd3, 3'd0});

        rxdisperr = 2'b01; step(); rxdisperr = 2'b00;
        step(15);
        rxdisperr = 2'b01; step(); rxdisperr = 2'b00;
        chk("err_beats_retire", err_cnt, 2);

        rxbyterealign = 1'b1; rxdisperr = 2'b11;
        step();
        rxbyterealign = 1'b0; rxdisperr = 2'b00;
        chk("realign_err_hunt", {state, err_cnt}, {2'd1, 3'd0});
        chk("realign_err_once", sync_loss_cnt, 2);

        seen = 0;
        for (int i = 0; i < 1022; i++) begin step(); if (hunt_timeout) seen++; end
        chk("no_early_timeout", seen, 0);
        step();
        chk("timeout_pulse", {state, hunt_timeout, rxpcommaalignen, rxmcommaalignen}, {2'd1, 3'b100});
        step();
        chk("timeout_one_cycle", {hunt_timeout, rxpcommaalignen, rxmcommaalignen}, 3'b011);
        seen = 0;
        for (int i = 0; i < 1021; i++) begin step(); if (hunt_timeout) seen++; end
        chk("no_early_timeout2", seen, 0);
        step();
        chk("timeout_repeat", hunt_timeout, 1);

        commas(1);
        chk("acq_again", state, 2);
        step();
        chk("acq_hold_noncomma", state, 2);
        commas(1);
        chk("acq_comma2", state, 2);
        commas(1);
        chk("acq_lock3", state, 3);

        rxelecidle = 1'b1;
        step();
        chk("elecidle_idle", state, 0);
        chk("elecidle_outs", {rxpcommaalignen, rxmcommaalignen, rxcommadeten, sync_ok}, 0);
        chk("elecidle_no_loss", sync_loss_cnt, 2);
        rxelecidle = 1'b0;
        step();
        chk("idle_rehunt", state, 1);
        commas(1);
        enable = 1'b0;
        step();
        chk("disable_idle", state, 0);
        enable = 1'b1;
        step();
        commas(1);
        chk("acq_before_rst", state, 2);

        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_outs", {rxpcommaalignen, rxmcommaalignen, rxcommadeten, sync_ok, hunt_timeout}, 0);
        chk("async_rst_cnts", {err_cnt, sync_loss_cnt}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
